// File: rtl/vctr_frame_decoder.sv
// Frame decoder for the vector controller: turns UART byte strobes into register writes.
// Frames are SYNC_BYTE, address, data; bad addresses and stalled frames are dropped and flagged.
module vctr_frame_decoder #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned NUM_REGS       = 4,
  parameter int unsigned TIMEOUT_CYCLES = 40000
) (
  input  logic                    clock,
  input  logic                    nrst,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic [8*NUM_REGS-1:0]   regs_flat,
  output logic                    frame_valid,
  output logic [7:0]              frame_addr,
  output logic [7:0]              frame_data,
  output logic                    frame_err,
  output logic [1:0]              err_code,
  output logic [7:0]              frame_cnt
);

  localparam logic [15:0] TmoLimit = 16'(TIMEOUT_CYCLES);
  localparam logic [1:0]  ErrAddr  = 2'b01;
  localparam logic [1:0]  ErrTmo   = 2'b10;

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e      state_q, state_d;
  logic [15:0] tmo_q, tmo_d;
  logic [15:0] tmo_inc;
  logic        tmo_hit;
  logic [7:0]  addr_q;
  logic        addr_ok;

  logic        do_latch, do_write, do_bad, do_tmo;

  logic [7:0]  regs_q [NUM_REGS];
  logic        frame_valid_q, frame_err_q;
  logic [7:0]  frame_addr_q, frame_data_q, frame_cnt_q;
  logic [1:0]  err_code_q;

  // A byte on the limit cycle wins over the timeout, so the hit is qualified by !rx_valid.
  assign tmo_inc = tmo_q + 16'd1;
  assign tmo_hit = !rx_valid && (tmo_inc == TmoLimit);
  assign addr_ok = ({24'd0, addr_q} < NUM_REGS);

  // State register
  always_ff @(posedge clock or posedge nrst) begin
    if (nrst) begin
      state_q <= StIdle;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state logic; the counter is cleared by every accepted byte and held at zero in idle.
  always_comb begin
    state_d = state_q;
    tmo_d   = '0;
    unique case (state_q)
      StIdle: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) state_d = StAddr;
      end
      StAddr: begin
        if (rx_valid)     state_d = StData;
        else if (tmo_hit) state_d = StIdle;
        else              tmo_d   = tmo_inc;
      end
      StData: begin
        if (rx_valid)     state_d = StIdle;
        else if (tmo_hit) state_d = StIdle;
        else              tmo_d   = tmo_inc;
      end
      default: state_d = StIdle;
    endcase
  end

  // Decoded actions for the datapath
  always_comb begin
    do_latch = 1'b0;
    do_write = 1'b0;
    do_bad   = 1'b0;
    do_tmo   = 1'b0;
    unique case (state_q)
      StIdle: ;
      StAddr: begin
        do_latch = rx_valid;
        do_tmo   = tmo_hit;
      end
      StData: begin
        do_write = rx_valid && addr_ok;
        do_bad   = rx_valid && !addr_ok;
        do_tmo   = tmo_hit;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge nrst) begin
    if (nrst) begin
      addr_q        <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_addr_q  <= '0;
      frame_data_q  <= '0;
      frame_cnt_q   <= '0;
      err_code_q    <= '0;
      for (int unsigned k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
    end else begin
      frame_valid_q <= do_write;
      frame_err_q   <= do_bad || do_tmo;
      if (do_latch) addr_q <= rx_data;
      if (do_write) begin
        frame_addr_q <= addr_q;
        frame_data_q <= rx_data;
        frame_cnt_q  <= frame_cnt_q + 8'd1;
      end
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
        if (do_write && (addr_q == 8'(k))) regs_q[k] <= rx_data;
      end
      if (do_bad)      err_code_q <= ErrAddr;
      else if (do_tmo) err_code_q <= ErrTmo;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[8*g +: 8] = regs_q[g];
  end

  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign frame_addr  = frame_addr_q;
  assign frame_data  = frame_data_q;
  assign frame_cnt   = frame_cnt_q;
  assign err_code    = err_code_q;

endmodule

// File: tb/tb_vctr_frame_decoder.sv
// Directed bench for vctr_frame_decoder: a byte-level model pushes expected strobes to a
// scoreboard that a negedge monitor pops; timeout shortened to keep runs short.
module tb_vctr_frame_decoder;

  localparam int NR  = 4;
  localparam int TMO = 200;
  localparam int GAP = 118;

  logic            clock = 1'b0;
  logic            nrst = 1'b1;
  logic [7:0]      rx_data = 8'h00;
  logic            rx_valid = 1'b0;
  logic [8*NR-1:0] regs_flat;
  logic            frame_valid, frame_err;
  logic [7:0]      frame_addr, frame_data, frame_cnt;
  logic [1:0]      err_code;

  vctr_frame_decoder #(
    .SYNC_BYTE(8'hA5),
    .NUM_REGS(NR),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock),
    .nrst(nrst),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .regs_flat(regs_flat),
    .frame_valid(frame_valid),
    .frame_addr(frame_addr),
    .frame_data(frame_data),
    .frame_err(frame_err),
    .err_code(err_code),
    .frame_cnt(frame_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic            is_err;
    logic [1:0]      code;
    logic [7:0]      addr;
    logic [7:0]      data;
    logic [7:0]      cnt;
    logic [8*NR-1:0] regs;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  int              m_state;
  int              m_tmo;
  logic [7:0]      m_addr;
  logic [7:0]      m_cnt;
  logic [1:0]      m_code;
  logic [8*NR-1:0] m_regs;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic is_err);
    exp_t e;
    e.is_err = is_err;
    e.code   = m_code;
    e.addr   = m_addr;
    e.data   = m_regs[8*m_addr[1:0] +: 8];
    e.cnt    = m_cnt;
    e.regs   = m_regs;
    sb.push_back(e);
  endtask

  task automatic model_reset();
    m_state = 0;
    m_tmo   = 0;
    m_addr  = 8'h00;
    m_cnt   = 8'h00;
    m_code  = 2'b00;
    m_regs  = '0;
    sb.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    case (m_state)
      0: if (b == 8'hA5) begin m_state = 1; m_tmo = 0; end
      1: begin m_addr = b; m_state = 2; m_tmo = 0; end
      default: begin
        if (m_addr < 8'(NR)) begin
          m_regs[8*m_addr[1:0] +: 8] = b;
          m_cnt = m_cnt + 8'd1;
          push(1'b0);
        end else begin
          m_code = 2'b01;
          push(1'b1);
        end
        m_state = 0;
      end
    endcase
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clock);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      if (m_state != 0) begin
        m_tmo++;
        if (m_tmo == TMO) begin
          m_code  = 2'b10;
          m_state = 0;
          push(1'b1);
        end
      end
    end
  endtask

  task automatic do_reset();
    nrst = 1'b1;
    model_reset();
    #2;
    check("rst_regs", 64'(regs_flat), 64'h0);
    check("rst_valid", 64'(frame_valid), 64'h0);
    check("rst_err", 64'(frame_err), 64'h0);
    check("rst_addr", 64'(frame_addr), 64'h0);
    check("rst_data", 64'(frame_data), 64'h0);
    check("rst_code", 64'(err_code), 64'h0);
    check("rst_cnt", 64'(frame_cnt), 64'h0);
    @(negedge clock);
    nrst = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic drain(input string tag);
    idle(3);
    check(tag, 64'(sb.size()), 64'h0);
  endtask

  always @(negedge clock) begin
    if (!nrst && (frame_valid || frame_err)) begin
      check("strobe_exclusive", 64'(frame_valid & frame_err), 64'h0);
      if (sb.size() == 0) begin
        check("unexpected_strobe", 64'({frame_valid, frame_err}), 64'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("strobe_kind", 64'(frame_err), 64'(e.is_err));
        check("err_code", 64'(err_code), 64'(e.code));
        check("regs_flat", 64'(regs_flat), 64'(e.regs));
        check("frame_cnt", 64'(frame_cnt), 64'(e.cnt));
        if (!e.is_err) begin
          check("frame_addr", 64'(frame_addr), 64'(e.addr));
          check("frame_data", 64'(frame_data), 64'(e.data));
        end
      end
    end
  end

  initial begin
    logic [7:0] stream [31] = '{8'hA5, 8'h01, 8'hAA, 8'h00, 8'h01, 8'hA5, 8'h02, 8'hBB,
                                8'hA5, 8'h03, 8'hCC, 8'hA5, 8'h03, 8'hDD, 8'h00, 8'h02,
                                8'hA5, 8'h00, 8'h11, 8'h51, 8'h53, 8'hA5, 8'h23, 8'hDD,
                                8'h01, 8'h78, 8'hA5, 8'h01, 8'h92, 8'h00, 8'h75};
    logic [7:0] b2b [6] = '{8'hA5, 8'h00, 8'h7E, 8'hA5, 8'h03, 8'h81};

    // First frame
    do_reset();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'hAA);
    drain("sb_first");
    check("first_reg1", 64'(regs_flat[15:8]), 64'hAA);
    check("first_cnt", 64'(frame_cnt), 64'h1);

    // Spaced stream with stray bytes and one bad address
    do_reset();
    foreach (stream[i]) begin
      send_byte(stream[i]);
      idle(GAP - 1);
    end
    drain("sb_stream");
    check("stream_regs", 64'(regs_flat), 64'hDDBB9211);
    check("stream_cnt", 64'(frame_cnt), 64'h6);
    check("stream_code", 64'(err_code), 64'h1);

    // Timeout in ADDR, then stray frame tail, then a good frame
    do_reset();
    send_byte(8'hA5);
    idle(TMO + 2);
    check("tmo_code", 64'(err_code), 64'h2);
    send_byte(8'h01); send_byte(8'h55);
    idle(2);
    check("tmo_nowrite", 64'(regs_flat), 64'h0);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h66);
    drain("sb_tmo");
    check("tmo_reg2", 64'(regs_flat[23:16]), 64'h66);

    // Back-to-back frames
    do_reset();
    foreach (b2b[i]) send_byte(b2b[i]);
    drain("sb_b2b");
    check("b2b_reg0", 64'(regs_flat[7:0]), 64'h7E);
    check("b2b_reg3", 64'(regs_flat[31:24]), 64'h81);
    check("b2b_cnt", 64'(frame_cnt), 64'h2);

    // Reset mid-frame
    do_reset();
    send_byte(8'hA5); send_byte(8'h02);
    do_reset();
    send_byte(8'h44);
    idle(2);
    check("midrst_regs", 64'(regs_flat), 64'h0);
    check("midrst_cnt", 64'(frame_cnt), 64'h0);
    check("midrst_addr", 64'(frame_addr), 64'h0);
    check("midrst_code", 64'(err_code), 64'h0);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h44);
    drain("sb_midrst");
    check("midrst_reg2", 64'(regs_flat[23:16]), 64'h44);

    // Data byte on the timeout-limit cycle is accepted
    do_reset();
    send_byte(8'hA5); send_byte(8'h00);
    idle(TMO - 1);
    send_byte(8'h5A);
    drain("sb_limit");
    check("limit_reg0", 64'(regs_flat[7:0]), 64'h5A);
    check("limit_code", 64'(err_code), 64'h0);

    // Timeout in DATA fires exactly TMO cycles after the address byte
    do_reset();
    send_byte(8'hA5); send_byte(8'h01);
    idle(TMO);
    drain("sb_tmo_data");
    check("tmo_data_code", 64'(err_code), 64'h2);

    // Frame counter wrap
    do_reset();
    for (int k = 0; k < 256; k++) begin
      send_byte(8'hA5); send_byte(8'(k % NR)); send_byte(8'(k));
    end
    drain("sb_wrap");
    check("wrap_cnt", 64'(frame_cnt), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
